// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - keypad digit accumulator with valid/ack hand-off (optional DIGIT_ENTRY_BACKSPACE_EN)
module digit_entry #(
    parameter int NDIG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4:0]                  digito,
    input  logic                        cambio_digito,
    input  logic                        out_ack,
    output logic [4*NDIG-1:0]           valor,
    output logic [$clog2(NDIG+1)-1:0]   ndig,
    output logic                        out_valid,
    output logic                        overflow,
    output logic                        key_event
);

    localparam int NW = $clog2(NDIG + 1);
    localparam logic [NW-1:0] NDIG_MAX = NW'(NDIG);
    localparam logic [NW-1:0] NDIG_ONE = NW'(1);

    localparam logic [4:0] KEY_BACK  = 5'h0D;
    localparam logic [4:0] KEY_ENTER = 5'h0E;
    localparam logic [4:0] KEY_CLEAR = 5'h0F;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_n;

    logic s1, s2, s3;
    logic evt;
    logic is_digit;

    logic [4*NDIG-1:0] valor_n;
    logic [NW-1:0]     ndig_n;
    logic              out_valid_n;
    logic              overflow_n;
    logic              key_event_n;

    // Toggle synchronizer plus history flop; any difference between s2 and s3 is one key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= cambio_digito;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // digito is sampled directly: the slow scanner keeps it stable long before s2 flips.
    assign evt      = s2 ^ s3;
    assign is_digit = (digito < 5'd10);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            valor     <= '0;
            ndig      <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            key_event <= 1'b0;
        end else begin
            state     <= state_n;
            valor     <= valor_n;
            ndig      <= ndig_n;
            out_valid <= out_valid_n;
            overflow  <= overflow_n;
            key_event <= key_event_n;
        end
    end

    // Next-state logic: key decoding per state, ack hand-off out of DONE.
    always_comb begin
        state_n     = state;
        valor_n     = valor;
        ndig_n      = ndig;
        out_valid_n = out_valid;
        overflow_n  = overflow;
        key_event_n = 1'b0;

        case (state)
            EMPTY: begin
                if (evt && is_digit) begin
                    valor_n      = '0;
                    valor_n[3:0] = digito[3:0];
                    ndig_n       = NDIG_ONE;
                    key_event_n  = 1'b1;
                    state_n      = ENTRY;
                end
            end

            ENTRY: begin
                if (evt) begin
                    if (is_digit) begin
                        if (ndig < NDIG_MAX) begin
                            valor_n      = valor << 4;
                            valor_n[3:0] = digito[3:0];
                            ndig_n       = ndig + NDIG_ONE;
                            key_event_n  = 1'b1;
                        end else begin
                            overflow_n = 1'b1;
                        end
                    end else if (digito == KEY_CLEAR) begin
                        valor_n     = '0;
                        ndig_n      = '0;
                        overflow_n  = 1'b0;
                        key_event_n = 1'b1;
                        state_n     = EMPTY;
                    end else if (digito == KEY_ENTER) begin
                        out_valid_n = 1'b1;
                        key_event_n = 1'b1;
                        state_n     = DONE;
`ifdef DIGIT_ENTRY_BACKSPACE_EN
                    end else if (digito == KEY_BACK) begin
                        valor_n     = valor >> 4;
                        ndig_n      = ndig - NDIG_ONE;
                        overflow_n  = 1'b0;
                        key_event_n = 1'b1;
                        if (ndig == NDIG_ONE) begin
                            state_n = EMPTY;
                        end
`endif
                    end
                end
            end

            DONE: begin
                // Key events are dropped here, including one that coincides with the ack.
                if (out_ack) begin
                    out_valid_n = 1'b0;
                    valor_n     = '0;
                    ndig_n      = '0;
                    overflow_n  = 1'b0;
                    state_n     = EMPTY;
                end
            end

            default: begin
                state_n     = EMPTY;
                valor_n     = '0;
                ndig_n      = '0;
                out_valid_n = 1'b0;
                overflow_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_digit_entry.sv
// tb/tb_digit_entry.sv - self-checking bench for digit_entry against a digit-queue model
module tb_digit_entry;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  digito = 5'h1F;
    logic        cambio = 1'b0;
    logic        out_ack = 1'b0;
    logic [15:0] valor;
    logic [2:0]  ndig;
    logic        out_valid;
    logic        overflow;
    logic        key_event;

    int tests = 0;
    int fails = 0;

    // Reference model: the entered number is a queue of decimal digits, most significant first.
    int q[$];
    bit m_done = 1'b0;
    bit m_ovf  = 1'b0;

    digit_entry #(.NDIG(NDIG)) dut (
        .clk           (clk),
        .rst           (rst),
        .digito        (digito),
        .cambio_digito (cambio),
        .out_ack       (out_ack),
        .valor         (valor),
        .ndig          (ndig),
        .out_valid     (out_valid),
        .overflow      (overflow),
        .key_event     (key_event)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_valor();
        logic [31:0] v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    // Returns 1 when the key is acted on.
    function automatic bit model_key(input int code);
        if (m_done) return 1'b0;
        if (code < 10) begin
            if (q.size() < NDIG) begin
                q.push_back(code);
                return 1'b1;
            end
            m_ovf = 1'b1;
            return 1'b0;
        end
        if (q.size() == 0) return 1'b0;
        if (code == 15) begin
            q.delete();
            m_ovf = 1'b0;
            return 1'b1;
        end
        if (code == 14) begin
            m_done = 1'b1;
            return 1'b1;
        end
`ifdef DIGIT_ENTRY_BACKSPACE_EN
        if (code == 13) begin
            void'(q.pop_back());
            m_ovf = 1'b0;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valor"}, 32'(valor), model_valor());
        check({tag, "_ndig"}, 32'(ndig), 32'(q.size()));
        check({tag, "_valid"}, 32'(out_valid), 32'(m_done));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic send_key(input logic [4:0] code, input bit with_ack, input string tag);
        bit acted;
        @(negedge clk);
        digito = code;
        cambio = ~cambio;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({tag, "_early_evt"}, 32'(key_event), 0);
        check({tag, "_early_valor"}, 32'(valor), model_valor());
        if (with_ack) out_ack = 1'b1;
        if (with_ack && m_done) begin
            model_reset();
            acted = 1'b0;
        end else begin
            acted = model_key(int'(code));
        end
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check({tag, "_evt"}, 32'(key_event), 32'(acted));
        check_model(tag);
        @(posedge clk);
        #1;
        check({tag, "_evt_end"}, 32'(key_event), 0);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        if (m_done) model_reset();
        check_model(tag);
        check({tag, "_evt"}, 32'(key_event), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        check("reset_evt", 32'(key_event), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // 1,2,3 -> 0x123
        send_key(5'd1, 1'b0, "k1");
        send_key(5'd2, 1'b0, "k2");
        send_key(5'd3, 1'b0, "k3");
        check("v123", 32'(valor), 32'h0123);
        send_key(5'hF, 1'b0, "clr0");

        // Overflow: 9,8,7,6,5 then clear
        send_key(5'd9, 1'b0, "o9");
        send_key(5'd8, 1'b0, "o8");
        send_key(5'd7, 1'b0, "o7");
        send_key(5'd6, 1'b0, "o6");
        send_key(5'd5, 1'b0, "o5");
        check("v9876", 32'(valor), 32'h9876);
        check("ovf_set", 32'(overflow), 1);
        send_key(5'hF, 1'b0, "oclr");
        check("ovf_clr", 32'(overflow), 0);

        // Enter, key in DONE, ack
        send_key(5'd4, 1'b0, "e4");
        send_key(5'd2, 1'b0, "e2");
        send_key(5'hE, 1'b0, "eE");
        check("v42", 32'(valor), 32'h0042);
        check("valid42", 32'(out_valid), 1);
        send_key(5'd7, 1'b0, "done7");
        do_ack("ack1");

        // Ignored keys in EMPTY and invalid code in ENTRY
        send_key(5'hE, 1'b0, "emptyE");
        send_key(5'hF, 1'b0, "emptyF");
        send_key(5'd3, 1'b0, "i3");
        send_key(5'd16, 1'b0, "i16");
        send_key(5'hA, 1'b0, "iA");
        send_key(5'hF, 1'b0, "iclr");

        // Backspace (or ignored 0xD)
        send_key(5'd5, 1'b0, "b5");
        send_key(5'd6, 1'b0, "b6");
        send_key(5'hD, 1'b0, "bD");
`ifdef DIGIT_ENTRY_BACKSPACE_EN
        check("bs_v5", 32'(valor), 32'h0005);
        send_key(5'hD, 1'b0, "bD2");
        check("bs_empty", 32'(ndig), 0);
`else
        check("nobs_v56", 32'(valor), 32'h0056);
        send_key(5'hF, 1'b0, "bclr");
`endif

        // Event coinciding with ack in DONE: ack wins, key dropped
        send_key(5'd8, 1'b0, "s8");
        send_key(5'hE, 1'b0, "sE");
        send_key(5'd9, 1'b1, "sack");
        check("sim_valid", 32'(out_valid), 0);
        send_key(5'd2, 1'b0, "after_ack");

        // Randomized key stream against the model
        for (int i = 0; i < 120; i++) begin
            int r;
            int code;
            r = $urandom_range(0, 11);
            if (r == 0 && m_done) begin
                do_ack("rack");
            end else begin
                if (r <= 5) code = $urandom_range(0, 9);
                else if (r <= 7) code = 14;
                else if (r == 8) code = 15;
                else if (r == 9) code = 13;
                else code = $urandom_range(10, 31);
                send_key(5'(code), 1'b0, "rnd");
            end
        end
        if (m_done) do_ack("rack_end");

        // Reset while DONE with a toggle pending in the synchronizer
        send_key(5'd1, 1'b0, "r1");
        send_key(5'hE, 1'b0, "rE");
        if (cambio == 1'b0) send_key(5'd7, 1'b0, "rpar");
        @(negedge clk);
        digito = 5'd3;
        cambio = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rst_now");
        check("rst_now_evt", 32'(key_event), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_evt", 32'(key_event), 0);
        end
        check_model("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
